// File: rtl/fifo_rr_wr_arbiter_if.sv
// Requester and FIFO-side signals of the round-robin write arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fifo_rr_wr_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 5
);
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic                     fifo_wr_en_o;
    logic [WIDTH-1:0]         fifo_wdata_o;
    logic                     fifo_rd_en_i;
    logic                     fifo_empty_i;
    logic                     fifo_wr_error_i;
    logic [CNT_WIDTH-1:0]     level_o;
    logic                     err_o;

    modport slave (
        input  req_i, wdata_i, fifo_rd_en_i, fifo_empty_i, fifo_wr_error_i,
        output gnt_o, fifo_wr_en_o, fifo_wdata_o, level_o, err_o
    );

    modport master (
        output req_i, wdata_i, fifo_rd_en_i, fifo_empty_i, fifo_wr_error_i,
        input  gnt_o, fifo_wr_en_o, fifo_wdata_o, level_o, err_o
    );
endinterface

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ requesters,
// with bursts of up to MAX_BURST beats and an occupancy counter that includes the in-flight write.
module fifo_rr_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_WIDTH = 5,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fifo_rr_wr_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic                 err_q, err_d;
    logic                 wr_en_q;
    logic [WIDTH-1:0]     wdata_q, wdata_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        sel, cand, acc_idx;
    logic                 found, credit, accept, burst_end, dec;
    logic [WIDTH-1:0]     slice;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (32'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    assign credit = (level_q < CNT_WIDTH'(DEPTH));

    // First requester at or above the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(rr_q) + k) % NUM_REQ);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Output logic; the grant is gated by reset so it clears asynchronously.
    always_comb begin
        gnt     = '0;
        acc_idx = owner_q;
        if (state_q == IDLE) begin
            acc_idx = sel;
            if (found && credit) gnt[sel] = 1'b1;
        end else if (bus.req_i[owner_q] && credit) begin
            gnt[owner_q] = 1'b1;
        end
        if (!rst_ni) gnt = '0;
    end

    assign accept = |(gnt & bus.req_i);

    always_comb begin
        slice = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            if (32'(acc_idx) == n) slice = bus.wdata_i[n*WIDTH +: WIDTH];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        burst_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = sel;
                    beat_d  = BW'(1);
                    if (MAX_BURST == 1) rr_d = wrap_inc(sel);
                    else                state_d = BURST;
                end
            end
            BURST: begin
                if (!bus.req_i[owner_q]) begin
                    burst_end = 1'b1;
                end else if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) burst_end = 1'b1;
                end
            end
        endcase
        if (burst_end) begin
            state_d = IDLE;
            rr_d    = wrap_inc(owner_q);
            beat_d  = '0;
        end
    end

    // A simultaneous write and read leaves the level unchanged.
    always_comb begin
        dec     = bus.fifo_rd_en_i & ~bus.fifo_empty_i;
        level_d = level_q;
        if (accept && !dec)                      level_d = level_q + 1'b1;
        else if (dec && !accept && level_q != '0) level_d = level_q - 1'b1;
        err_d   = err_q | bus.fifo_wr_error_i | (dec && (level_q == '0));
        wdata_d = accept ? slice : wdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            level_q <= level_d;
            err_q   <= err_d;
            wr_en_q <= accept;
            wdata_q <= wdata_d;
        end
    end

    assign bus.gnt_o        = gnt;
    assign bus.fifo_wr_en_o = wr_en_q;
    assign bus.fifo_wdata_o = wdata_q;
    assign bus.level_o      = level_q;
    assign bus.err_o        = err_q;
endmodule

// File: doc/fifo_rr_wr_arbiter.md
# fifo_rr_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ requesters. Each requester presents data with a request; the arbiter grants one requester per cycle, holds the grant for bursts of up to MAX_BURST beats, and drives a registered write into the FIFO. An internal occupancy counter, which includes in-flight writes, guarantees that no write is ever issued into a full FIFO.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width
- DEPTH, 16, FIFO depth in entries
- CNT_WIDTH, 5, occupancy counter width; must satisfy 2^CNT_WIDTH > DEPTH
- MAX_BURST, 4, maximum consecutive beats granted to one owner (≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request; data valid while high
- wdata_i  in  NUM_REQ*WIDTH  packed request data; requester n uses bits [n*WIDTH +: WIDTH]
- gnt_o  out  NUM_REQ  one-hot grant (combinational); req_i[n] & gnt_o[n] at a rising edge = beat accepted
- fifo_wr_en_o  out  1  registered FIFO write enable
- fifo_wdata_o  out  WIDTH  registered FIFO write data
- fifo_rd_en_i  in  1  FIFO read enable, observed for credit return
- fifo_empty_i  in  1  FIFO empty flag
- fifo_wr_error_i  in  1  FIFO write-error flag
- level_o  out  CNT_WIDTH  occupancy: FIFO entries plus in-flight write
- err_o  out  1  sticky error flag

## Operation
- Reset values: gnt_o = 0, fifo_wr_en_o = 0, fifo_wdata_o = 0, level_o = 0, err_o = 0, state = IDLE, owner = 0, rr pointer = 0, beat count = 0.
- Credit: `credit = (level_o < DEPTH)`. No grant is asserted while credit = 0. A same-cycle read does not create credit.
- **IDLE:** if any req_i is high and credit = 1, gnt_o selects the first requester with req_i high, searching from the rr pointer upward modulo NUM_REQ. When that beat is accepted: owner ← selected requester, beat count ← 1. If MAX_BURST = 1, the arbiter stays in IDLE and sets rr pointer ← owner+1; otherwise it moves to BURST.
- **BURST:** gnt_o[owner] = req_i[owner] & credit.
  - An accepted beat increments beat count.
  - The burst ends when beat count reaches MAX_BURST on an accepted beat, or when req_i[owner] is low. On burst end: state ← IDLE, rr pointer ← (owner+1) mod NUM_REQ, beat count ← 0.
  - Credit stall (req_i[owner] high, credit = 0): the arbiter stays in BURST, grants nothing, and ownership is kept.
- **Accepted beat:** at that edge, fifo_wr_en_o ← 1 and fifo_wdata_o ← the owner's wdata_i slice. Otherwise fifo_wr_en_o ← 0 and fifo_wdata_o holds its value.
- **level_o updates each edge:**
  - +1 on an accepted beat.
  - −1 when fifo_rd_en_i & !fifo_empty_i.
  - Unchanged when both occur in the same cycle.
  - Never decrements below 0.
- **err_o:** set on fifo_wr_error_i = 1, or on a decrement attempted with level_o = 0 while fifo_empty_i = 0 (count mismatch). It is cleared only by reset.
- Non-owner request changes have no effect during BURST. A requester may drop req_i at any time; there is no grant without a request.

## Timing
- Grant is combinational in cycle t. The beat is accepted at edge t. The FIFO samples fifo_wr_en_o and writes at edge t+1. Request-to-FIFO latency is 1 cycle.
- Throughput is 1 beat per cycle, including back-to-back bursts across different owners. There is no dead cycle between IDLE re-arbitration and a new grant.
- level_o counts a write at acceptance, one cycle before the FIFO's full flag reflects it. This is why the arbiter never drives fifo_wr_en_o into a full FIFO.
- Asynchronous reset mid-burst: all state clears immediately, and any pending fifo_wr_en_o drops without completing. After reset is released, arbitration restarts from requester 0.
- level_o wraps never: its range is 0..DEPTH.

## Test plan
- **Single requester:** req_i = 4'b0001 for 6 cycles with data 0x10..0x15, MAX_BURST = 4. Expect gnt_o[0] high for beats 1-4; IDLE for 0 cycles; a new burst of 2. fifo_wr_en_o follows acceptance by 1 cycle, and the FIFO contains 0x10..0x15 in order.
- **Round-robin fairness:** all four requesters request continuously with MAX_BURST = 1. Expect grant order 0,1,2,3,0,1,… with one beat each and 100% write utilisation.
- **Full back-pressure:** no reads and continuous requests. level_o reaches 16, then gnt_o = 0 and no 17th write is issued (fifo_wr_error_i stays 0). After one read, exactly one new grant follows.
- **Simultaneous read and write at level 16→15:** expect level_o stays at 15 during steady one-in/one-out operation. The write stream continues at 1 beat per cycle after the first credit is returned.
- **Owner drops mid-burst:** req_i[2] drops after 2 beats while req_i[3] is high. Expect state to return to IDLE and the next grant to go to requester 3 in the following cycle.
- **Reset mid-burst:** assert rst_ni low during beat 3. Expect gnt_o, fifo_wr_en_o and level_o at 0 asynchronously. After release with all requests high, the first grant goes to requester 0.
